// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state and output-select encodings for uart_tx_framer.
// BREAK is always enumerated; it is only reachable when UART_TX_BREAK_EN is defined.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_BREAK
    } state_t;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'b00,
        SEL_DATA = 2'b01,
        SEL_PAR  = 2'b10,
        SEL_ONE  = 2'b11
    } sel_t;

endpackage

// File: rtl/uart_tx_out_sel.sv
// uart_tx_out_sel: 4:1 line-level select (0/data/parity/1) registered onto the serial pin.
// The register resets to 1 so the line idles high.
module uart_tx_out_sel
    import uart_tx_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  sel_t sel,
    input  logic data_bit,
    input  logic par_bit,
    output logic tx
);

    logic nxt;

    always_comb
        nxt = sel == SEL_ZERO ? 1'b0 :
              sel == SEL_DATA ? data_bit :
              sel == SEL_PAR  ? par_bit : 1'b1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            tx <= 1'b1;
        else
            tx <= nxt;

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART transmit framer, one bit per clock, optional parity and 1/2 stop bits.
// Define UART_TX_BREAK_EN to enable the BREAK_REQ line-break state.
module uart_tx_framer
    import uart_tx_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic                  BREAK_REQ,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    state_t                  state, nxt;
    sel_t                    sel;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   shift;
    logic                    par_q, par_en_q, stop2_q;
    logic                    last, accept;

    assign last   = cnt == CNT_W'(DATA_WIDTH - 1);
    assign accept = state == S_IDLE && nxt == S_START;
    assign BUSY   = state != S_IDLE;

`ifndef UART_TX_BREAK_EN
    logic unused_break;
    assign unused_break = BREAK_REQ;
`endif

    always_comb begin
        nxt = state;
        sel = SEL_ONE;
        case (state)
`ifdef UART_TX_BREAK_EN
            S_IDLE:   nxt = BREAK_REQ ? S_BREAK : DATA_VALID ? S_START : S_IDLE;
            S_BREAK: begin
                sel = SEL_ZERO;
                nxt = BREAK_REQ ? S_BREAK : S_STOP1;
            end
`else
            S_IDLE:   nxt = DATA_VALID ? S_START : S_IDLE;
`endif
            S_START: begin
                sel = SEL_ZERO;
                nxt = S_DATA;
            end
            S_DATA: begin
                sel = SEL_DATA;
                nxt = !last ? S_DATA : par_en_q ? S_PARITY : S_STOP1;
            end
            S_PARITY: begin
                sel = SEL_PAR;
                nxt = S_STOP1;
            end
            S_STOP1:  nxt = stop2_q ? S_STOP2 : S_IDLE;
            S_STOP2:  nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    // Frame config is latched only on accept; an idle clear keeps a break's stop cycle single.
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            shift    <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= (state == S_DATA && !last) ? cnt + CNT_W'(1) : '0;
            if (accept) begin
                shift    <= P_DATA;
                par_q    <= ^P_DATA ^ PAR_TYP;
                par_en_q <= PAR_EN;
                stop2_q  <= STOP2;
            end else if (state == S_DATA) begin
                shift <= shift >> 1;
            end else if (state == S_IDLE) begin
                stop2_q <= 1'b0;
            end
        end

    uart_tx_out_sel u_out_sel (
        .clk      (CLK),
        .rst_n    (RST),
        .sel      (sel),
        .data_bit (shift[0]),
        .par_bit  (par_q),
        .tx       (TX_OUT)
    );

endmodule
